wb_mem_arbiter: RTL and testbench
=================================

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 SHALL have parameter WDT_CYCLES, default 1024, watchdog limit in clk cycles (power of 2, 16..65536).
REQ-002 SHALL have port clk  in  1  single clock for all logic and both Wishbone sides.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i  in  1 each  master k cycle, strobe and write enable.
REQ-005 SHALL have ports m0_addr_i, m1_addr_i  in  [31:2]  master k word address.
REQ-006 SHALL have ports mk_cti_i in 3, mk_bte_i in 2, mk_sel_i in 4, mk_data_i in 32, for k=0,1  master k burst and byte-lane controls and write data.
REQ-007 SHALL have ports mk_data_o out 32, mk_ack_o out 1, mk_err_o out 1, for k=0,1  master k read data, acknowledge and error.
REQ-008 SHALL have ports s_cyc_o, s_stb_o, s_we_o out 1; s_addr_o out [31:2]; s_cti_o out 3; s_bte_o out 2; s_sel_o out 4; s_data_o out 32  shared slave request.
REQ-009 SHALL have ports s_data_i in 32 and s_ack_i in 1  shared slave response.
REQ-010 SHALL have port grant_o  out  2  one-hot current owner, 00 when idle.

Function
REQ-011 SHALL implement states IDLE, OWN0, OWN1 and ABORT.
REQ-012 In IDLE, if exactly one mk_cyc_i is high, SHALL enter OWNk at the next clk edge.
REQ-013 In IDLE with both cyc high, SHALL grant the master not served last; the last-served pointer SHALL reset to 1, so m0 wins first.
REQ-014 In OWNk, SHALL drive all s_* request outputs combinationally from master k; in other states s_cyc_o, s_stb_o and s_we_o SHALL be 0, and the remaining s_* outputs SHALL be 0.
REQ-015 SHALL route s_ack_i and s_data_i only to the owner; the non-owner SHALL see ack=0 and data_o=0.
REQ-016 SHALL hold ownership while the owner's cyc stays high, including across cti bursts and stb-low gaps.
REQ-017 When the owner drops cyc with the other cyc high, SHALL move directly OWNk -> OWN(1-k) with no IDLE cycle; otherwise it SHALL move to IDLE.
REQ-018 On every transition into OWNk, SHALL set the last-served pointer to k.
REQ-019 Arbitration latency from cyc rising in IDLE to s_cyc_o rising SHALL be exactly 1 clk.
REQ-020 A master dropping cyc in the same cycle as s_ack_i SHALL complete that transfer (ack forwarded), then release.
REQ-021 grant_o SHALL be 2'b01 in OWN0, 2'b10 in OWN1 and 2'b00 in IDLE and ABORT.

Reset
REQ-022 Asserting rst_n low SHALL immediately force IDLE, last-served pointer 1, watchdog count 0, and all outputs 0, including mid-transfer.
REQ-023 After rst_n deasserts, SHALL first arbitrate on the next rising clk edge.

Configuration
REQ-024 With macro ARB_WATCHDOG_EN defined, SHALL count clk cycles in OWNk while stb is high and s_ack_i is low, clearing the count on ack or on an ownership change.
REQ-025 With ARB_WATCHDOG_EN, when the count reaches WDT_CYCLES-1, SHALL pulse mk_err_o for 1 clk to the owner and enter ABORT.
REQ-026 In ABORT, s_cyc_o SHALL stay 0; the block SHALL return to IDLE once the aborted master drops cyc, and the pointer SHALL then favour the other master.
REQ-027 Without ARB_WATCHDOG_EN, no counter SHALL exist, ABORT SHALL be unreachable and mk_err_o SHALL be constant 0.

Verification
REQ-028 After reset, raise m0_cyc and m1_cyc in the same cycle -> grant_o=01 one clk later; drop m0_cyc -> grant_o=10 on the next clk, with no idle gap.
REQ-029 m1 runs an 8-beat incrementing burst (cti=010, last beat 111) with m0 requesting throughout -> all 8 acks go to m1, m0 sees ack=0, and handover occurs after m1 drops cyc.
REQ-030 m0 reads address 0x100 and the slave returns 0xDEADBEEF with ack -> m0_data_o=0xDEADBEEF and m1_data_o=0.
REQ-031 rst_n is pulled low mid-burst while in OWN1 -> s_cyc_o=0 and grant_o=00 within the same cycle, without waiting for clk.
REQ-032 With ARB_WATCHDOG_EN and WDT_CYCLES=16, the slave never acks m0 -> m0_err_o pulses at cycle 15 of stb, s_cyc_o=0, and a pending m1 is granted after m0 drops cyc.
REQ-033 Without the macro, the same stimulus as REQ-032 -> m0 holds the grant indefinitely and m0_err_o stays 0.

Source files
------------

// File: rtl/wb_mem_arbiter.sv
// Two-master to one-slave Wishbone arbiter with round-robin tie-break.
// The owner keeps the slave for as long as its cyc stays high. Request outputs are muxed
// combinationally from the owner, and the slave response is routed back to the owner only.
// Optional watchdog, enabled by defining ARB_WATCHDOG_EN: an owner that waits WDT_CYCLES
// strobed cycles without an ack gets an err pulse and is locked out until it drops cyc.
module wb_mem_arbiter #(
  parameter int unsigned WDT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  // master 0
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:2] m0_addr_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:2] m1_addr_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // shared slave
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:2] s_addr_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  // one-hot current owner
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StAbort} state_e;

  state_e      state_q;
  logic        last_q;      // master served most recently; the other one wins a tie
  logic        abort_id_q;  // master locked out while in StAbort
  logic [1:0]  grant_q;
  logic        own0;
  logic        own1;
  logic        wdt_fire;

  assign own0    = (state_q == StOwn0);
  assign own1    = (state_q == StOwn1);
  assign grant_o = grant_q;

  // Slave request follows the owner; everything is quiet when nobody owns the bus.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    s_sel_o  = '0;
    s_data_o = '0;
    if (own0) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_cti_o  = m0_cti_i;
      s_bte_o  = m0_bte_i;
      s_sel_o  = m0_sel_i;
      s_data_o = m0_data_i;
    end else if (own1) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_addr_o = m1_addr_i;
      s_cti_o  = m1_cti_i;
      s_bte_o  = m1_bte_i;
      s_sel_o  = m1_sel_i;
      s_data_o = m1_data_i;
    end
  end

  // Slave response goes to the owner only, even when the owner drops cyc on the ack cycle.
  always_comb begin
    m0_ack_o  = own0 & s_ack_i;
    m1_ack_o  = own1 & s_ack_i;
    m0_data_o = own0 ? s_data_i : '0;
    m1_data_o = own1 ? s_data_i : '0;
    m0_err_o  = own0 & wdt_fire;
    m1_err_o  = own1 & wdt_fire;
  end

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(WDT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(WDT_CYCLES - 1);

  logic [CntW-1:0] wdt_cnt_q;
  logic            owner_cyc;
  logic            owner_stb;

  assign owner_cyc = own0 ? m0_cyc_i : (own1 ? m1_cyc_i : 1'b0);
  assign owner_stb = own0 ? m0_stb_i : (own1 ? m1_stb_i : 1'b0);
  assign wdt_fire  = owner_cyc & owner_stb & ~s_ack_i & (wdt_cnt_q == CntMax);

  // Count strobed, unacked cycles of the current owner; any ack or release restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt_q <= '0;
    end else if (!owner_cyc || s_ack_i) begin
      wdt_cnt_q <= '0;
    end else if (owner_stb) begin
      wdt_cnt_q <= wdt_cnt_q + CntW'(1);
    end
  end
`else
  logic unused_wdt;
  assign unused_wdt = ^WDT_CYCLES;
  assign wdt_fire   = 1'b0;
`endif

  // Ownership FSM; grant is registered alongside the state it decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      abort_id_q <= 1'b0;
      grant_q    <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= StOwn0;
            last_q  <= 1'b0;
            grant_q <= 2'b01;
          end else if (m1_cyc_i) begin
            state_q <= StOwn1;
            last_q  <= 1'b1;
            grant_q <= 2'b10;
          end
        end
        StOwn0: begin
          if (wdt_fire) begin
            state_q    <= StAbort;
            abort_id_q <= 1'b0;
            grant_q    <= 2'b00;
          end else if (!m0_cyc_i) begin
            if (m1_cyc_i) begin
              state_q <= StOwn1;
              last_q  <= 1'b1;
              grant_q <= 2'b10;
            end else begin
              state_q <= StIdle;
              grant_q <= 2'b00;
            end
          end
        end
        StOwn1: begin
          if (wdt_fire) begin
            state_q    <= StAbort;
            abort_id_q <= 1'b1;
            grant_q    <= 2'b00;
          end else if (!m1_cyc_i) begin
            if (m0_cyc_i) begin
              state_q <= StOwn0;
              last_q  <= 1'b0;
              grant_q <= 2'b01;
            end else begin
              state_q <= StIdle;
              grant_q <= 2'b00;
            end
          end
        end
        StAbort: begin
          // Wait for the aborted master to give up; the other master then wins any tie.
          if (!(abort_id_q ? m1_cyc_i : m0_cyc_i)) begin
            state_q <= StIdle;
            last_q  <= abort_id_q;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: directed table, hand sequences (burst, async reset, watchdog)
// and a randomized run against an ownership-level reference model.
module tb_wb_mem_arbiter;

  localparam int unsigned Wdt = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // master inputs, index = master number
  logic [1:0]        cyc, stb, we;
  logic [1:0][29:0]  addr;
  logic [1:0][2:0]   cti;
  logic [1:0][1:0]   bte;
  logic [1:0][3:0]   sel;
  logic [1:0][31:0]  wdat;
  logic [31:0]       s_dat;
  logic              s_ack;

  logic [31:0] m0_data_o, m1_data_o, s_data_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:2] s_addr_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;

  wb_mem_arbiter #(.WDT_CYCLES(Wdt)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]),
    .m0_cti_i(cti[0]), .m0_bte_i(bte[0]), .m0_sel_i(sel[0]), .m0_data_i(wdat[0]),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]),
    .m1_cti_i(cti[1]), .m1_bte_i(bte[1]), .m1_sel_i(sel[1]), .m1_data_i(wdat[1]),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_sel_o(s_sel_o), .s_data_o(s_data_o),
    .s_data_i(s_dat), .s_ack_i(s_ack), .grant_o(grant_o)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
  endtask

  task automatic idle_inputs();
    cyc = '0; stb = '0; we = '0; cti = '0; bte = '0; wdat = '0;
    sel = {4'hf, 4'hf};
    addr[0] = 30'h40;  // byte address 0x100
    addr[1] = 30'h80;
    s_dat = '0; s_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- reference model: who owns the bus, in plain integers ----------------
  int own;   // -1 nobody, else master number
  int abt;   // -1 not aborted, else locked-out master
  int last;  // master served most recently
  int wcnt;  // strobed cycles the owner has waited without an ack

  task automatic model_reset();
    own = -1; abt = -1; last = 1; wcnt = 0;
  endtask

  function automatic logic fire();
`ifdef ARB_WATCHDOG_EN
    return own >= 0 && cyc[own] && stb[own] && !s_ack && wcnt == int'(Wdt) - 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [127:0] req_vec(input int o);
    if (o < 0) return '0;
    return {54'b0, cyc[o], stb[o], we[o], addr[o], cti[o], bte[o], sel[o], wdat[o]};
  endfunction

  task automatic check_model();
    logic [1:0] g;
    logic       f;
    f = fire();
    g = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
    chk("rand_grant", grant_o, g);
    chk("rand_req", {54'b0, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_cti_o, s_bte_o, s_sel_o,
                     s_data_o}, req_vec(own));
    chk("rand_m0_resp", {m0_ack_o, m0_err_o, m0_data_o}, (own == 0) ? {s_ack, f, s_dat} : 34'b0);
    chk("rand_m1_resp", {m1_ack_o, m1_err_o, m1_data_o}, (own == 1) ? {s_ack, f, s_dat} : 34'b0);
  endtask

  task automatic model_step();
    logic f;
    f = fire();
    if (abt >= 0) begin
      if (!cyc[abt]) begin last = abt; abt = -1; end
    end else if (own < 0) begin
      if (cyc == 2'b11) own = 1 - last;
      else if (cyc[0]) own = 0;
      else if (cyc[1]) own = 1;
      if (own >= 0) last = own;
      wcnt = 0;
    end else if (f) begin
      abt = own; own = -1; wcnt = 0;
    end else if (!cyc[own]) begin
      if (cyc[1 - own]) begin own = 1 - own; last = own; end
      else own = -1;
      wcnt = 0;
    end else if (s_ack) begin
      wcnt = 0;
    end else if (stb[own]) begin
      wcnt++;
    end
  endtask

  task automatic rand_inputs(input int unsigned ack_div);
    for (int k = 0; k < 2; k++) begin
      if ($urandom_range(0, 5) == 0) cyc[k] = ~cyc[k];
      stb[k]  = 1'($urandom_range(0, 1));
      we[k]   = 1'($urandom_range(0, 1));
      addr[k] = 30'($urandom);
      cti[k]  = 3'($urandom);
      bte[k]  = 2'($urandom);
      sel[k]  = 4'($urandom);
      wdat[k] = $urandom;
    end
    s_ack = ($urandom_range(0, ack_div - 1) == 0);
    s_dat = $urandom;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        c0, c1, ack;
    logic [31:0] sdat;
    logic [1:0]  g;
    logic        scyc, a0, a1;
    logic [31:0] d0, d1;
  } vec_t;

  function automatic vec_t v(input logic c0, c1, ack, input logic [31:0] sdat,
                             input logic [1:0] g, input logic scyc, a0, a1,
                             input logic [31:0] d0, d1);
    vec_t r;
    r.c0 = c0; r.c1 = c1; r.ack = ack; r.sdat = sdat; r.g = g;
    r.scyc = scyc; r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1;
    return r;
  endfunction

  vec_t tbl[16];

  initial begin
    logic [29:0] exp_addr;

    // each row: inputs driven for one cycle, outputs expected in that same cycle
    tbl[0]  = v(1, 1, 0, 0,            2'b00, 0, 0, 0, 0, 0);  // reset-released IDLE
    tbl[1]  = v(1, 1, 0, 0,            2'b01, 1, 0, 0, 0, 0);  // tie: m0 first
    tbl[2]  = v(0, 1, 0, 0,            2'b01, 0, 0, 0, 0, 0);  // m0 drops cyc
    tbl[3]  = v(0, 1, 0, 0,            2'b10, 1, 0, 0, 0, 0);  // direct handover
    tbl[4]  = v(1, 1, 1, 32'h1111,     2'b10, 1, 0, 1, 0, 32'h1111);
    tbl[5]  = v(1, 0, 1, 32'h2222,     2'b10, 0, 0, 1, 0, 32'h2222);  // drop with ack
    tbl[6]  = v(1, 0, 0, 0,            2'b01, 1, 0, 0, 0, 0);
    tbl[7]  = v(1, 0, 1, 32'hDEADBEEF, 2'b01, 1, 1, 0, 32'hDEADBEEF, 0);
    tbl[8]  = v(0, 0, 0, 0,            2'b01, 0, 0, 0, 0, 0);
    tbl[9]  = v(0, 0, 0, 0,            2'b00, 0, 0, 0, 0, 0);
    tbl[10] = v(1, 1, 0, 32'h55,       2'b00, 0, 0, 0, 0, 0);  // idle: no data leak
    tbl[11] = v(1, 1, 0, 0,            2'b10, 1, 0, 0, 0, 0);  // tie: m1 (m0 was last)
    tbl[12] = v(1, 0, 0, 0,            2'b10, 0, 0, 0, 0, 0);
    tbl[13] = v(1, 0, 0, 0,            2'b01, 1, 0, 0, 0, 0);
    tbl[14] = v(0, 0, 0, 0,            2'b01, 0, 0, 0, 0, 0);
    tbl[15] = v(0, 0, 1, 32'h77,       2'b00, 0, 0, 0, 0, 0);  // idle: no ack leak

    // reset with requests and ack present: everything must stay quiet
    idle_inputs();
    rst_n = 1'b0;
    cyc = 2'b11; stb = 2'b11; s_ack = 1'b1; s_dat = 32'hABCD;
    #12;
    chk("reset_grant", grant_o, 2'b00);
    chk("reset_s_cyc", {s_cyc_o, s_stb_o, s_we_o, s_addr_o}, 0);
    chk("reset_resp", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_data_o, m1_data_o}, 0);
    idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      cyc = {tbl[i].c1, tbl[i].c0}; stb = cyc;
      s_ack = tbl[i].ack; s_dat = tbl[i].sdat;
      @(negedge clk);
      exp_addr = (tbl[i].g == 2'b01) ? addr[0] : ((tbl[i].g == 2'b10) ? addr[1] : 30'h0);
      chk($sformatf("tbl%0d_grant", i), grant_o, tbl[i].g);
      chk($sformatf("tbl%0d_s_cyc_addr", i), {s_cyc_o, s_addr_o}, {tbl[i].scyc, exp_addr});
      chk($sformatf("tbl%0d_m0", i), {m0_ack_o, m0_data_o}, {tbl[i].a0, tbl[i].d0});
      chk($sformatf("tbl%0d_m1", i), {m1_ack_o, m1_data_o}, {tbl[i].a1, tbl[i].d1});
      step();
    end

    // 8-beat incrementing burst by m1 while m0 keeps requesting (m0 was served last)
    idle_inputs();
    cyc = 2'b11; stb = 2'b11;
    step();
    for (int b = 0; b < 8; b++) begin
      cti[1] = (b == 7) ? 3'b111 : 3'b010;
      s_ack = 1'b1; s_dat = 32'hB000_0000 + 32'(b);
      @(negedge clk);
      chk("burst_grant", grant_o, 2'b10);
      chk("burst_m1", {m1_ack_o, m1_data_o}, {1'b1, 32'hB000_0000 + 32'(b)});
      chk("burst_m0", {m0_ack_o, m0_data_o}, 0);
      chk("burst_cti", s_cti_o, (b == 7) ? 3'b111 : 3'b010);
      step();
    end
    cyc[1] = 1'b0; stb[1] = 1'b0; s_ack = 1'b0; cti = '0;
    @(negedge clk);
    chk("burst_release_grant", grant_o, 2'b10);
    step();
    @(negedge clk);
    chk("burst_handover", {grant_o, s_cyc_o}, {2'b01, 1'b1});
    step();

    // asynchronous reset in the middle of an m1 transfer
    cyc = 2'b10; stb = 2'b10; s_ack = 1'b1;
    step();
    chk("pre_reset_grant", grant_o, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_s_cyc", s_cyc_o, 1'b0);
    chk("async_reset_grant", grant_o, 2'b00);
    chk("async_reset_m1_ack", m1_ack_o, 1'b0);
    idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    step();

    // slave never acks m0, m1 waits
    cyc = 2'b11; stb = 2'b11;
    step();
`ifdef ARB_WATCHDOG_EN
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      chk("wdt_err", {m0_err_o, m1_err_o}, {n == 15, 1'b0});
      chk("wdt_s_cyc", s_cyc_o, 1'b1);
      step();
    end
    @(negedge clk);
    chk("wdt_abort", {grant_o, s_cyc_o, m0_err_o}, 0);
    step();
    @(negedge clk);
    chk("wdt_abort_hold", {grant_o, s_cyc_o}, 0);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    step();
    @(negedge clk);
    chk("wdt_idle", grant_o, 2'b00);
    step();
    @(negedge clk);
    chk("wdt_m1_granted", {grant_o, s_cyc_o}, {2'b10, 1'b1});
    step();
`else
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      chk("nowdt_err", {m0_err_o, m1_err_o}, 0);
      chk("nowdt_grant", {grant_o, s_cyc_o}, {2'b01, 1'b1});
      step();
    end
`endif

    // randomized run against the reference model
    idle_inputs();
    rst_n = 1'b0;
    #3;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    step();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs((i < 1500) ? 2 : 16);
      @(negedge clk);
      check_model();
      model_step();
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
